// File: rtl/demux_pkg.sv
// Shared types and constants for the demux_buffer lanes.
// The counter constants are used only when DEMUX_BUFFER_STATS_EN is defined.
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    localparam int          COUNT_WIDTH = 16;
    localparam logic [15:0] COUNT_SAT   = 16'hFFFF;

endpackage

// File: rtl/demux_lane.sv
// One single-entry output lane: EMPTY/FULL FSM, payload register and,
// when DEMUX_BUFFER_STATS_EN is defined, a saturating delivery counter.
module demux_lane
    import demux_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [data_width-1:0]  i_data,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic                   o_xfer,
    output logic [data_width-1:0]  o_data
`ifdef DEMUX_BUFFER_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0] o_count
`endif
);

    lane_state_t           r_state;
    lane_state_t           w_nextState;
    logic [data_width-1:0] r_data;

    assign o_valid = (r_state == FULL);
    assign o_xfer  = o_valid & i_ready;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A load into a FULL lane is only possible alongside a transfer, so FULL stays FULL.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            EMPTY:   if (i_load) w_nextState = FULL;
            FULL:    if (o_xfer && !i_load) w_nextState = EMPTY;
            default: w_nextState = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

`ifdef DEMUX_BUFFER_STATS_EN
    logic [COUNT_WIDTH-1:0] r_count;

    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (o_xfer && (r_count != COUNT_SAT)) begin
            r_count <= r_count + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/demux_buffer.sv
// 1-to-N demultiplexer with an independent single-entry buffer per output lane.
// Define DEMUX_BUFFER_STATS_EN to add per-lane delivery counters on count_OUT.
module demux_buffer
    import demux_pkg::*;
#(
    parameter int switch_bits = 1,
    parameter int data_width  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  valid_IN,
    input  logic [switch_bits-1:0]                sel_IN,
    input  logic [data_width-1:0]                 data_IN,
    output logic                                  ready_OUT,
    output logic [(2**switch_bits)-1:0]           valid_OUT,
    output logic [(2**switch_bits)*data_width-1:0] data_OUT,
    input  logic [(2**switch_bits)-1:0]           ready_IN
`ifdef DEMUX_BUFFER_STATS_EN
    ,
    output logic [(2**switch_bits)*COUNT_WIDTH-1:0] count_OUT
`endif
);

    localparam int LANES = 2**switch_bits;

    logic [LANES-1:0] w_valid;
    logic [LANES-1:0] w_xfer;
    logic [LANES-1:0] w_load;
    logic             w_ready;

    // Readiness looks only at the selected lane, never at valid_IN, and is held low in reset.
    assign w_ready   = !rst && (!w_valid[sel_IN] || w_xfer[sel_IN]);
    assign ready_OUT = w_ready;
    assign valid_OUT = w_valid;

    always_comb begin
        w_load = '0;
        if (valid_IN && w_ready) begin
            w_load[sel_IN] = 1'b1;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        demux_lane #(
            .data_width(data_width)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_load[g]),
            .i_data (data_IN),
            .i_ready(ready_IN[g]),
            .o_valid(w_valid[g]),
            .o_xfer (w_xfer[g]),
            .o_data (data_OUT[g*data_width +: data_width])
`ifdef DEMUX_BUFFER_STATS_EN
            ,
            .o_count(count_OUT[g*COUNT_WIDTH +: COUNT_WIDTH])
`endif
        );
    end

endmodule

// File: tb/tb_demux_buffer.sv
// Directed self-checking bench for demux_buffer with two and four lanes.
// Counter checks are compiled in when DEMUX_BUFFER_STATS_EN is defined.
module tb_demux_buffer;

    logic        clk = 1'b0;
    logic        rst;

    logic        valid1;
    logic [0:0]  sel1;
    logic [7:0]  data1;
    logic        readyOut1;
    logic [1:0]  validOut1;
    logic [15:0] dataOut1;
    logic [1:0]  readyIn1;

    logic        valid2;
    logic [1:0]  sel2;
    logic [7:0]  data2;
    logic        readyOut2;
    logic [3:0]  validOut2;
    logic [31:0] dataOut2;
    logic [3:0]  readyIn2;

`ifdef DEMUX_BUFFER_STATS_EN
    logic [31:0] count1;
    logic [63:0] count2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_buffer #(.switch_bits(1), .data_width(8)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .valid_IN (valid1),
        .sel_IN   (sel1),
        .data_IN  (data1),
        .ready_OUT(readyOut1),
        .valid_OUT(validOut1),
        .data_OUT (dataOut1),
        .ready_IN (readyIn1)
`ifdef DEMUX_BUFFER_STATS_EN
        ,
        .count_OUT(count1)
`endif
    );

    demux_buffer #(.switch_bits(2), .data_width(8)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .valid_IN (valid2),
        .sel_IN   (sel2),
        .data_IN  (data2),
        .ready_OUT(readyOut2),
        .valid_OUT(validOut2),
        .data_OUT (dataOut2),
        .ready_IN (readyIn2)
`ifdef DEMUX_BUFFER_STATS_EN
        ,
        .count_OUT(count2)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [7:0] d, input logic [1:0] r);
        valid1   = v;
        sel1     = s;
        data1    = d;
        readyIn1 = r;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid2 = 1'b0; sel2 = '0; data2 = '0; readyIn2 = '0;
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00);
        tick();
        tick();
        checkOutput("rst_valid", 32'(validOut1), 32'h0);
        checkOutput("rst_data", 32'(dataOut1), 32'h0);
        checkOutput("rst_ready", 32'(readyOut1), 32'h0);
        rst = 1'b0;
        #1;
        checkOutput("idle_ready", 32'(readyOut1), 32'h1);

        // Word to lane 1 while lane 1 is stalled
        applyStimulus(1'b1, 1'b1, 8'hA5, 2'b00);
        checkOutput("acc1_ready", 32'(readyOut1), 32'h1);
        tick();
        checkOutput("acc1_valid", 32'(validOut1), 32'h2);
        checkOutput("acc1_data", 32'(dataOut1[15:8]), 32'hA5);
        checkOutput("full1_ready", 32'(readyOut1), 32'h0);
        applyStimulus(1'b0, 1'b1, 8'hFF, 2'b00);
        checkOutput("full1_ready_novalid", 32'(readyOut1), 32'h0);

        // Payload must be ignored when valid is low
        applyStimulus(1'b0, 1'b0, 8'hFF, 2'b00);
        tick();
        checkOutput("novalid_valid", 32'(validOut1), 32'h2);
        checkOutput("novalid_data", 32'(dataOut1), 32'hA500);

        // Stalled lane 1 does not block lane 0
        applyStimulus(1'b1, 1'b0, 8'h3C, 2'b00);
        checkOutput("indep_ready", 32'(readyOut1), 32'h1);
        tick();
        checkOutput("indep_valid", 32'(validOut1), 32'h3);
        checkOutput("indep_data", 32'(dataOut1), 32'hA53C);
        checkOutput("indep_full0_ready", 32'(readyOut1), 32'h0);

        // Transfer and accept on lane 0 in the same cycle
        applyStimulus(1'b1, 1'b0, 8'h55, 2'b01);
        checkOutput("pass_ready", 32'(readyOut1), 32'h1);
        tick();
        checkOutput("pass_valid", 32'(validOut1), 32'h3);
        checkOutput("pass_data", 32'(dataOut1), 32'hA555);
`ifdef DEMUX_BUFFER_STATS_EN
        checkOutput("pass_count", count1, 32'h0000_0001);
`endif
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b01);
        tick();
        checkOutput("drain_valid", 32'(validOut1), 32'h2);
        checkOutput("drain_data1", 32'(dataOut1[15:8]), 32'hA5);
`ifdef DEMUX_BUFFER_STATS_EN
        checkOutput("drain_count", count1, 32'h0000_0002);
`endif

        // Full stalled lane holds its word
        applyStimulus(1'b1, 1'b1, 8'h77, 2'b00);
        checkOutput("hold_ready", 32'(readyOut1), 32'h0);
        tick();
        checkOutput("hold_data", 32'(dataOut1[15:8]), 32'hA5);
        checkOutput("hold_valid", 32'(validOut1), 32'h2);

        // Refill lane 0, then reset with everything full and downstream ready
        applyStimulus(1'b1, 1'b0, 8'h9A, 2'b00);
        tick();
        checkOutput("refill_valid", 32'(validOut1), 32'h3);
        checkOutput("refill_data", 32'(dataOut1), 32'hA59A);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h11, 2'b11);
        checkOutput("midrst_ready", 32'(readyOut1), 32'h0);
        tick();
        checkOutput("midrst_valid", 32'(validOut1), 32'h0);
        checkOutput("midrst_data", 32'(dataOut1), 32'h0);
`ifdef DEMUX_BUFFER_STATS_EN
        checkOutput("midrst_count", count1, 32'h0);
`endif
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00);

        // Four-lane instance: fill every lane
        for (int i = 0; i < 4; i++) begin
            valid2 = 1'b1;
            sel2   = 2'(i);
            data2  = 8'(i + 1);
            #1;
            checkOutput($sformatf("fill%0d_ready", i), 32'(readyOut2), 32'h1);
            tick();
        end
        valid2 = 1'b0;
        checkOutput("fill_valid", 32'(validOut2), 32'hF);
        checkOutput("fill_data", dataOut2, 32'h04030201);
        sel2 = 2'd2;
        #1;
        checkOutput("fill_ready_full", 32'(readyOut2), 32'h0);
        readyIn2 = 4'b0100;
        tick();
        readyIn2 = 4'b0000;
        checkOutput("lane2_drain_valid", 32'(validOut2), 32'hB);
        checkOutput("lane2_drain_data", dataOut2, 32'h04030201);
`ifdef DEMUX_BUFFER_STATS_EN
        checkOutput("lane2_count", count2[47:32], 32'h0001);

        // Stream into lane 0 with downstream always ready until the counter saturates
        applyStimulus(1'b1, 1'b0, 8'h5A, 2'b01);
        for (int k = 0; k < 11; k++) tick();
        checkOutput("stream_count10", 32'(count1[15:0]), 32'h000A);
        for (int k = 0; k < 65531; k++) tick();
        checkOutput("stream_sat", 32'(count1[15:0]), 32'hFFFF);
        tick();
        checkOutput("stream_sat_hold", 32'(count1[15:0]), 32'hFFFF);
        checkOutput("stream_lane1_count", 32'(count1[31:16]), 32'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_buffer.md
DEMUX_BUFFER -- requirements
Module: demux_buffer

Interface
REQ-001 SHALL have parameter switch_bits, default 1: select width; output lane count N = 2**switch_bits.
REQ-002 SHALL have parameter data_width, default 8: payload width per word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port valid_IN  input  1  upstream word present.
REQ-006 SHALL have port sel_IN  input  switch_bits  destination lane of the current word.
REQ-007 SHALL have port data_IN  input  data_width  upstream payload.
REQ-008 SHALL have port ready_OUT  output  1  upstream word accepted this cycle when high with valid_IN.
REQ-009 SHALL have port valid_OUT  output  N  per-lane word present; bit i = lane i.
REQ-010 SHALL have port data_OUT  output  N*data_width  per-lane payload; lane i at bits [i*data_width +: data_width].
REQ-011 SHALL have port ready_IN  input  N  per-lane downstream accept.
REQ-012 SHALL have port count_OUT  output  N*16  per-lane delivered-word count; present only under REQ-030.

Function
REQ-013 SHALL hold one single-entry buffer per lane, each a two-state FSM: EMPTY, FULL.
REQ-014 Lane i SHALL drive valid_OUT[i]=1 exactly when in FULL; data_OUT lane i SHALL equal the buffered word.
REQ-015 Downstream transfer on lane i SHALL occur when valid_OUT[i] and ready_IN[i] are both high.
REQ-016 ready_OUT SHALL be combinational: 1 when lane sel_IN is EMPTY or has a downstream transfer in the same cycle; else 0.
REQ-017 ready_OUT SHALL NOT depend on valid_IN, and sel_IN/data_IN SHALL be ignored when valid_IN=0.
REQ-018 Upstream accept (valid_IN & ready_OUT) SHALL load data_IN into lane sel_IN; valid_OUT of that lane SHALL rise on the next cycle (latency 1).
REQ-019 Transitions: EMPTY->FULL on accept; FULL->EMPTY on transfer without accept; FULL->FULL on transfer and accept in the same cycle, buffer takes new word (no bubble).
REQ-020 A FULL lane without transfer SHALL hold its data stable and ignore data_IN.
REQ-021 Lanes SHALL be independent: a stalled lane SHALL NOT block accepts to other lanes.
REQ-022 Only lane sel_IN SHALL change state due to an upstream accept; other lanes change only by their own transfers.

Reset
REQ-023 While rst=1 at a clk edge, all lanes SHALL go EMPTY; valid_OUT SHALL be all zeros the next cycle.
REQ-024 data_OUT SHALL reset to all zeros.
REQ-025 count_OUT (if present) SHALL reset to all zeros.
REQ-026 Reset mid-operation SHALL discard all buffered words; no transfer or accept SHALL be credited in a reset cycle.
REQ-027 During reset, ready_OUT SHALL be 0.

Configuration
REQ-028 Macro DEMUX_BUFFER_STATS_EN SHALL control per-lane delivery counters.
REQ-029 Without it, count_OUT SHALL not exist and no counter logic SHALL be built.
REQ-030 With it, count_OUT lane i SHALL increment by 1 on each lane-i downstream transfer, saturating at 16'hFFFF.

Structure
REQ-031 Shared package demux_pkg SHALL hold the lane-state enum (EMPTY, FULL), the counter width constant (16), and its saturation value.
REQ-032 Each lane SHALL be one instance of sub-module demux_lane (FSM, data register, optional counter), generated N times.

Verification
REQ-033 Reset then valid_IN=1, sel_IN=1, data_IN=8'hA5, ready_IN=2'b00 -> next cycle valid_OUT=2'b10, data_OUT[15:8]=8'hA5, ready_OUT=0 for sel_IN=1.
REQ-034 Lane 1 FULL and stalled, valid_IN=1, sel_IN=0, data_IN=8'h3C -> ready_OUT=1; next cycle valid_OUT=2'b11, lane 1 still 8'hA5.
REQ-035 Lane 0 FULL, ready_IN[0]=1 and accept of 8'h55 to lane 0 in the same cycle -> lane 0 stays FULL with 8'h55, no bubble.
REQ-036 switch_bits=2: send 8'h01..8'h04 to lanes 0..3 with all ready_IN=0 -> valid_OUT=4'hF, data_OUT=32'h04030201.
REQ-037 rst=1 asserted while all lanes FULL -> next cycle valid_OUT=0, data_OUT=0, count_OUT=0.
REQ-038 With DEMUX_BUFFER_STATS_EN: 65,540 transfers on lane 0 -> count_OUT[15:0]=16'hFFFF.
